// File: rtl/shift_pkg.sv
// Shared types for the iterative shift unit: shift mode encoding and controller states.
package shift_pkg;

  typedef enum logic [1:0] {
    SM_ASR = 2'b00,
    SM_LSR = 2'b01,
    SM_LSL = 2'b10,
    SM_ROR = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// Single-position shifter: combinational, one bit per call, in any of the four shift modes.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] operand,
  input  shift_mode_t      mode,
  output logic [WIDTH-1:0] result
);

  logic signed [WIDTH-1:0] operand_s;

  assign operand_s = operand;

  always_comb begin
    result = operand;
    case (mode)
      SM_ASR:  result = operand_s >>> 1;
      SM_LSR:  result = {1'b0, operand[WIDTH-1:1]};
      SM_LSL:  result = {operand[WIDTH-2:0], 1'b0};
      SM_ROR:  result = {operand[0], operand[WIDTH-1:1]};
      default: result = operand;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: loads an operand, then shifts one position per clock for the requested amount.
module iterative_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  shift_state_t     state, state_nxt;
  shift_mode_t      mode_q;
  logic [AMT_W-1:0] count;
  logic [WIDTH-1:0] stepped;
  logic             load, step_en;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .operand (out),
    .mode    (mode_q),
    .result  (stepped)
  );

  // A new request is only accepted outside SHIFT; DONE accepts so results can stream back-to-back.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step_en   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = (amount != '0) ? ST_SHIFT : ST_DONE;
        end else if (state == ST_DONE) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        step_en = 1'b1;
        if (count == AMT_W'(1)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      out    <= '0;
      count  <= '0;
      mode_q <= SM_ASR;
    end else begin
      state <= state_nxt;
      if (load) begin
        out    <= in;
        count  <= amount;
        mode_q <= shift_mode_t'(mode);
      end else if (step_en) begin
        out   <= stepped;
        count <= count - AMT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter (WIDTH=16): directed cases plus randomized ops against an arithmetic model.
module tb_iterative_shifter;

  localparam int WIDTH = 16;
  localparam int AMT_W = 5;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] in;
  logic [AMT_W-1:0] amount;
  logic [1:0]       mode;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  iterative_shifter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .in     (in),
    .amount (amount),
    .mode   (mode),
    .out    (out),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Whole shift done in one go with plain arithmetic operators.
  function automatic logic [15:0] ref_shift(input logic [15:0] a, input int n, input logic [1:0] m);
    logic [31:0] d;
    int          r;
    ref_shift = a;
    case (m)
      2'b00: ref_shift = (n >= 16) ? {16{a[15]}} : 16'($signed(a) >>> n);
      2'b01: ref_shift = (n >= 16) ? 16'h0 : (a >> n);
      2'b10: ref_shift = (n >= 16) ? 16'h0 : 16'(a << n);
      default: begin
        r = n % 16;
        d = {a, a} >> r;
        ref_shift = d[15:0];
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is observed high.
  task automatic op(input logic [15:0] a, input int n, input logic [1:0] m,
                    input logic [15:0] exp, input bit hold_start, input string tag);
    int  k;
    int  busy_cnt;
    start  = 1'b1;
    in     = a;
    amount = AMT_W'(n);
    mode   = m;
    k = 0;
    busy_cnt = 0;
    while (k < 64) begin
      @(negedge clk);
      k++;
      if (busy) busy_cnt++;
      if (done) break;
      if (hold_start) begin
        in     = 16'($urandom);
        amount = 5'($urandom);
        mode   = 2'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, "_lat"}, k, n + 1);
    chk({tag, "_busy"}, busy_cnt, n);
    chk({tag, "_out"}, int'(out), int'(exp));
  endtask

  task automatic idle_hold(input logic [15:0] exp, input string tag);
    @(negedge clk);
    chk({tag, "_idle_done"}, int'(done), 0);
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_idle_out"}, int'(out), int'(exp));
  endtask

  initial begin
    logic [15:0] a;
    int          n;
    logic [1:0]  m;

    rst_n  = 1'b0;
    start  = 1'b0;
    in     = '0;
    amount = '0;
    mode   = '0;
    #12;
    chk("rst_out", int'(out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op(16'h8000, 3, 2'b00, 16'hF000, 1'b0, "asr");
    idle_hold(16'hF000, "asr");
    idle_hold(16'hF000, "asr2");
    op(16'h8000, 3, 2'b01, 16'h1000, 1'b0, "lsr");
    op(16'h0001, 15, 2'b10, 16'h8000, 1'b0, "lsl15");
    op(16'h0001, 16, 2'b10, 16'h0000, 1'b0, "lsl16");
    op(16'h0001, 1, 2'b11, 16'h8000, 1'b0, "ror1");
    op(16'hA5C3, 16, 2'b11, 16'hA5C3, 1'b0, "ror16");
    op(16'hA5C3, 0, 2'b11, 16'hA5C3, 1'b0, "amt0");
    idle_hold(16'hA5C3, "amt0");

    op(16'h1234, 6, 2'b10, 16'h8D00, 1'b1, "held_start");
    op(16'h00F0, 4, 2'b01, 16'h000F, 1'b0, "b2b");
    idle_hold(16'h000F, "b2b");

    // Reset asserted between edges while count==2 of a five-step operation.
    start  = 1'b1;
    in     = 16'h1234;
    amount = 5'd5;
    mode   = 2'b10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", int'(out), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_done", int'(done), 0);
      chk("post_rst_out", int'(out), 0);
    end

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      n = int'($urandom_range(0, 31));
      m = 2'($urandom);
      op(a, n, m, ref_shift(a, n, m), ($urandom_range(0, 3) == 0), "rnd");
      if ($urandom_range(0, 1) == 1) idle_hold(ref_shift(a, n, m), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
